// File: rtl/gray_code_generator_if.sv
// Gray-code generator bus: count control inputs plus the valid/ready code output.
// master = generator side, slave = upstream control / downstream consumer side.
interface gray_code_generator_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] b;
  logic             g_valid;
  logic             g_ready;
  logic             tc;

  modport master (
    input  en, up_dn, load, load_bin, g_ready,
    output g, b, g_valid, tc
  );

  modport slave (
    output en, up_dn, load, load_bin, g_ready,
    input  g, b, g_valid, tc
  );
endinterface

// File: rtl/gray_code_generator.sv
// Gray-code count generator: an up/down binary counter whose value is emitted
// as registered Gray code (plus the matching binary) under valid/ready flow
// control, with load, wrap-or-saturate limits and a terminal-count pulse.
module gray_code_generator #(
  parameter int WIDTH = 4,
  parameter bit WRAP  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  gray_code_generator_if.master bus
);

  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_g;
  logic             r_valid;
  logic             r_tc;

  logic             w_xfer;
  logic             w_adv;
  logic             w_at_limit;
  logic [WIDTH-1:0] w_b_next;

  function automatic logic [WIDTH-1:0] f_gray(input logic [WIDTH-1:0] v);
    return v ^ (v >> 1);
  endfunction

  // Handshake decode and next count value; at a limit a saturating counter holds.
  always_comb begin
    w_xfer     = r_valid & bus.g_ready;
    w_adv      = bus.en & (~r_valid | bus.g_ready);
    w_at_limit = bus.up_dn ? (r_b == {WIDTH{1'b1}}) : (r_b == {WIDTH{1'b0}});
    if (w_at_limit && (WRAP == 1'b0)) begin
      w_b_next = r_b;
    end else if (bus.up_dn) begin
      w_b_next = r_b + 1'b1;
    end else begin
      w_b_next = r_b - 1'b1;
    end
  end

  // Counter/output registers: reset > load > advance > idle (drain on transfer).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_b     <= '0;
      r_g     <= '0;
      r_valid <= 1'b1;
      r_tc    <= 1'b0;
    end else if (bus.load) begin
      r_b     <= bus.load_bin;
      r_g     <= f_gray(bus.load_bin);
      r_valid <= 1'b1;
      r_tc    <= 1'b0;
    end else if (w_adv) begin
      r_b     <= w_b_next;
      r_g     <= f_gray(w_b_next);
      r_valid <= 1'b1;
      r_tc    <= w_at_limit;
    end else begin
      if (w_xfer) begin
        r_valid <= 1'b0;
      end
      r_tc <= 1'b0;
    end
  end

  assign bus.g       = r_g;
  assign bus.b       = r_b;
  assign bus.g_valid = r_valid;
  assign bus.tc      = r_tc;

endmodule

// File: tb/tb_gray_code_generator.sv
// Bench for gray_code_generator: one wrapping and one saturating instance share
// stimulus; a counting model is compared every cycle and directed vectors pin
// hand-computed codes.
module tb_gray_code_generator;
  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gray_code_generator_if #(.WIDTH(W)) ifa ();
  gray_code_generator_if #(.WIDTH(W)) ifs ();

  gray_code_generator #(.WIDTH(W), .WRAP(1'b1)) u_wrap (.clk(clk), .rst(rst), .bus(ifa));
  gray_code_generator #(.WIDTH(W), .WRAP(1'b0)) u_sat  (.clk(clk), .rst(rst), .bus(ifs));

  int tests  = 0;
  int failed = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // k=0 wrapping instance, k=1 saturating instance
  task automatic chk_out(input string name, input int k, input int eg, input int eb,
                         input int ev, input int etc);
    int ag, ab, av, at;
    ag = (k == 0) ? int'(ifa.g)       : int'(ifs.g);
    ab = (k == 0) ? int'(ifa.b)       : int'(ifs.b);
    av = (k == 0) ? int'(ifa.g_valid) : int'(ifs.g_valid);
    at = (k == 0) ? int'(ifa.tc)      : int'(ifs.tc);
    chk({name, ".g"}, ag, eg);
    chk({name, ".b"}, ab, eb);
    chk({name, ".valid"}, av, ev);
    chk({name, ".tc"}, at, etc);
  endtask

  task automatic set_in(input logic r, input logic e, input logic u, input logic l,
                        input logic [W-1:0] lb, input logic rdy);
    rst = r;
    ifa.en = e;  ifa.up_dn = u;  ifa.load = l;  ifa.load_bin = lb;  ifa.g_ready = rdy;
    ifs.en = e;  ifs.up_dn = u;  ifs.load = l;  ifs.load_bin = lb;  ifs.g_ready = rdy;
  endtask

  // Behavioural model: an integer count with a pending-code flag.
  int mb[2];
  int mv[2];
  int mt[2];
  logic m_init = 1'b0;

  always @(posedge clk) begin
    if (rst) m_init <= 1'b1;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mb[k] <= 0; mv[k] <= 1; mt[k] <= 0;
      end else if (ifa.load) begin
        mb[k] <= int'(ifa.load_bin); mv[k] <= 1; mt[k] <= 0;
      end else if (ifa.en && (mv[k] == 0 || ifa.g_ready)) begin
        mv[k] <= 1;
        if (ifa.up_dn) begin
          if (mb[k] == MAXV) begin
            mt[k] <= 1; mb[k] <= (k == 0) ? 0 : MAXV;
          end else begin
            mt[k] <= 0; mb[k] <= mb[k] + 1;
          end
        end else begin
          if (mb[k] == 0) begin
            mt[k] <= 1; mb[k] <= (k == 0) ? MAXV : 0;
          end else begin
            mt[k] <= 0; mb[k] <= mb[k] - 1;
          end
        end
      end else begin
        if (mv[k] != 0 && ifa.g_ready) mv[k] <= 0;
        mt[k] <= 0;
      end
    end
  end

  task automatic chk_model(input int k);
    int ag, ab, av, at;
    ag = (k == 0) ? int'(ifa.g)       : int'(ifs.g);
    ab = (k == 0) ? int'(ifa.b)       : int'(ifs.b);
    av = (k == 0) ? int'(ifa.g_valid) : int'(ifs.g_valid);
    at = (k == 0) ? int'(ifa.tc)      : int'(ifs.tc);
    chk((k == 0) ? "model_wrap.valid" : "model_sat.valid", av, mv[k]);
    chk((k == 0) ? "model_wrap.tc"    : "model_sat.tc",    at, mt[k]);
    if (mv[k] != 0) begin
      chk((k == 0) ? "model_wrap.g" : "model_sat.g", ag, mb[k] ^ (mb[k] >> 1));
      chk((k == 0) ? "model_wrap.b" : "model_sat.b", ab, mb[k]);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (m_init) begin
      chk_model(0);
      chk_model(1);
    end
  end

  int seq[17] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};

  initial begin
    int prev_g;
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    repeat (2) @(negedge clk);
    chk_out("reset_wrap", 0, 0, 0, 1, 0);
    chk_out("reset_sat",  1, 0, 0, 1, 0);

    // Free-running up count through the wrap
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
    prev_g = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      chk("up_seq.g", int'(ifa.g), seq[i]);
      chk("up_seq.b", int'(ifa.b), i % 16);
      chk("up_seq.tc", int'(ifa.tc), (i == 16) ? 1 : 0);
      chk("up_seq.onebit", $countones(int'(ifa.g) ^ prev_g), 1);
      prev_g = int'(ifa.g);
    end
    chk_out("sat_at_top", 1, 8, 15, 1, 1);

    // Backpressure holds the code, then one new code per cycle
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_out("bp_hold", 0, 0, 0, 1, 0);
      chk_out("bp_hold_sat", 1, 8, 15, 1, 0);
    end
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
    @(negedge clk); chk_out("bp_rel1", 0, 1, 1, 1, 0);
    @(negedge clk); chk_out("bp_rel2", 0, 3, 2, 1, 0);
    @(negedge clk); chk_out("bp_rel3", 0, 2, 3, 1, 0);

    // Count down from zero
    set_in(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b1);
    @(negedge clk); chk_out("load0", 0, 0, 0, 1, 0);
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
    @(negedge clk);
    chk_out("down_wrap", 0, 8, 15, 1, 1);
    chk_out("down_sat",  1, 0, 0, 1, 1);
    @(negedge clk);
    chk_out("down_next", 0, 9, 14, 1, 0);
    chk_out("down_sat2", 1, 0, 0, 1, 1);

    // Load beats advance and discards the pending code
    set_in(1'b0, 1'b1, 1'b0, 1'b1, 4'd10, 1'b0);
    @(negedge clk); chk_out("load_win", 0, 15, 10, 1, 0);
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    @(negedge clk); chk_out("load_hold", 0, 15, 10, 1, 0);
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
    @(negedge clk); chk_out("drain", 0, 15, 10, 0, 0);
    @(negedge clk); chk_out("idle_empty", 0, 15, 10, 0, 0);
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    @(negedge clk); chk_out("refill", 0, 14, 11, 1, 0);

    // Saturation at the top, then reverse
    set_in(1'b0, 1'b0, 1'b1, 1'b1, 4'd15, 1'b1);
    @(negedge clk); chk_out("load15_sat", 1, 8, 15, 1, 0);
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk_out("sat_up", 1, 8, 15, 1, 1);
    end
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
    @(negedge clk); chk_out("sat_down", 1, 9, 14, 1, 0);

    // Mid-stream reset
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    @(negedge clk);
    chk_out("mid_rst_wrap", 0, 0, 0, 1, 0);
    chk_out("mid_rst_sat",  1, 0, 0, 1, 0);
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
